// File: rtl/fir_pkg.sv
// Shared constants and the result-narrowing helper for the FIR output collector.
// Define FIR_COLLECT_SAT_EN to saturate narrowed results instead of wrapping them.
package fir_pkg;

    localparam int SIZE_DEFAULT = 8;

    // Widest shifted value the narrowing helper accepts (covers SIZE up to 32).
    localparam int NARROW_MAX_W = 64;

    function automatic int fifo_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [NARROW_MAX_W-1:0] narrow(
        input logic [NARROW_MAX_W-1:0] value,
        input int                      size
    );
        logic [NARROW_MAX_W-1:0] mask;
        mask = {NARROW_MAX_W{1'b1}} >> (NARROW_MAX_W - size);
`ifdef FIR_COLLECT_SAT_EN
        if ((value & ~mask) != '0) begin
            return mask;
        end
        return value;
`else
        return value & mask;
`endif
    endfunction

endpackage

// File: rtl/collector_fifo.sv
// Result FIFO for the FIR collector: DEPTH entries, no bypass,
// and a full-accepting write when a pop happens on the same edge.
module collector_fifo
    import fir_pkg::*;
#(
    parameter int W     = SIZE_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [W-1:0]                   push_data,
    input  logic                           pop_ready,
    output logic [W-1:0]                   head_data,
    output logic                           head_valid,
    output logic [fifo_count_w(DEPTH)-1:0] count,
    output logic                           overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fifo_count_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;

    logic full;
    logic empty;
    logic pop;
    logic wr_en;
    logic drop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign pop   = pop_ready & ~empty;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        count_next = count_reg;
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Head is forced to zero when empty so reset leaves out_data at 0.
    assign head_data  = empty ? '0 : mem[rd_ptr_reg];
    assign head_valid = ~empty;
    assign count      = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: rtl/fir_out_collector.sv
// Aligns the PE-chain output with a TAPS-deep valid delay line, narrows it and queues it.
// Optional feature: FIR_COLLECT_SAT_EN selects saturating instead of wrapping narrowing.
module fir_out_collector
    import fir_pkg::*;
#(
    parameter int SIZE  = SIZE_DEFAULT,
    parameter int TAPS  = 4,
    parameter int SHIFT = 0,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [2*SIZE-1:0]              pe_y,
    output logic [SIZE-1:0]                out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [fifo_count_w(DEPTH)-1:0] fifo_count,
    output logic                           overflow
);

    logic [TAPS-1:0] valid_reg;
    logic [SIZE-1:0] result;

    // Stage TAPS-1 high means pe_y holds a real result at the coming edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
        end else begin
            valid_reg[0] <= in_valid;
            for (int i = 1; i < TAPS; i++) begin
                valid_reg[i] <= valid_reg[i-1];
            end
        end
    end

    assign result = SIZE'(narrow(NARROW_MAX_W'(pe_y >> SHIFT), SIZE));

    collector_fifo #(
        .W     (SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (valid_reg[TAPS-1]),
        .push_data  (result),
        .pop_ready  (out_ready),
        .head_data  (out_data),
        .head_valid (out_valid),
        .count      (fifo_count),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_fir_out_collector.sv
// Directed, scoreboard-checked bench for fir_out_collector (SIZE=8, TAPS=4, DEPTH=4).
module tb_fir_out_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] pe_y;
    logic        out_ready;

    logic [7:0]  out_data;
    logic        out_valid;
    logic [2:0]  fifo_count;
    logic        overflow;

    logic [7:0]  out_data_sh;
    logic        out_valid_sh;
    logic [2:0]  fifo_count_sh;
    logic        overflow_sh;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  sb [$];
    logic [15:0] hist [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

    always #5 clk = ~clk;

    fir_out_collector #(.SIZE(8), .TAPS(4), .SHIFT(0), .DEPTH(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .pe_y       (pe_y),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    fir_out_collector #(.SIZE(8), .TAPS(4), .SHIFT(4), .DEPTH(4)) u_dut_sh (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .pe_y       (pe_y),
        .out_data   (out_data_sh),
        .out_valid  (out_valid_sh),
        .out_ready  (out_ready),
        .fifo_count (fifo_count_sh),
        .overflow   (overflow_sh)
    );

    function automatic logic [7:0] tb_narrow(input logic [15:0] y, input int sh);
        logic [15:0] v;
        v = y >> sh;
`ifdef FIR_COLLECT_SAT_EN
        return (v > 16'd255) ? 8'hFF : v[7:0];
`else
        return v[7:0];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pe_y models the chain output: a sample's product appears four cycles after its in_valid.
    task automatic step(input logic v, input logic [15:0] val);
        in_valid = v;
        pe_y     = hist[3];
        hist[3]  = hist[2];
        hist[2]  = hist[1];
        hist[1]  = hist[0];
        hist[0]  = val;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                check("sb_data", 32'(out_data), 32'(e));
                $display("[TB] pop data=%0h expected=%0h", out_data, e);
            end
        end
    end

    initial begin
        int cnt_exp [4] = '{3, 4, 4, 4};
        int ov_exp  [4] = '{0, 0, 1, 1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        pe_y      = 16'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_count_sh", 32'(fifo_count_sh), 0);
        reset = 1'b0;

        // Alignment: one pulse, write lands on the fourth edge after it
        step(1'b1, 16'h0042);
        check("align_e0", 32'(out_valid), 0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 16'h0);
            check("align_early", 32'(out_valid), 0);
        end
        sb.push_back(8'h42);
        step(1'b0, 16'h0);
        check("align_valid", 32'(out_valid), 1);
        check("align_data", 32'(out_data), 32'h42);
        check("align_count", 32'(fifo_count), 1);
        out_ready = 1'b1;
        step(1'b0, 16'h0);
        out_ready = 1'b0;
        check("align_drained", 32'(fifo_count), 0);

        // Narrowing on both the unshifted and the SHIFT=4 instance
        sb.push_back(tb_narrow(16'h1234, 0));
        step(1'b1, 16'h1234);
        repeat (4) step(1'b0, 16'h0);
        check("narrow_sh4", 32'(out_data_sh), 32'(tb_narrow(16'h1234, 4)));
        check("narrow_sh0", 32'(out_data), 32'(tb_narrow(16'h1234, 0)));
        out_ready = 1'b1;
        repeat (2) step(1'b0, 16'h0);
        check("narrow_sh_drained", 32'(fifo_count_sh), 0);

        // Empty: out_ready held high must not underflow
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0);
            check("empty_count", 32'(fifo_count), 0);
            check("empty_valid", 32'(out_valid), 0);
        end
        out_ready = 1'b0;

        // Fill/overflow: samples 5 and 6 are dropped
        for (int v = 1; v <= 6; v++) begin
            step(1'b1, 16'(v));
            if (v <= 4) sb.push_back(8'(v));
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0);
            check("fill_count", 32'(fifo_count), 32'(cnt_exp[i]));
            check("fill_ovf", 32'(overflow), 32'(ov_exp[i]));
        end
        check("fill_head", 32'(out_data), 1);
        out_ready = 1'b1;
        repeat (4) step(1'b0, 16'h0);
        out_ready = 1'b0;
        check("fill_drained", 32'(fifo_count), 0);
        check("fill_empty_valid", 32'(out_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);

        reset = 1'b1;
        step(1'b0, 16'h0);
        reset = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // Full push/pop: sample 9 written on the same edge that pops 5
        for (int v = 5; v <= 9; v++) sb.push_back(8'(v));
        for (int i = 0; i <= 8; i++) begin
            out_ready = (i == 8);
            step(i < 5, (i < 5) ? 16'(5 + i) : 16'h0);
            if (i == 7) check("pp_full", 32'(fifo_count), 4);
        end
        check("pp_count", 32'(fifo_count), 4);
        check("pp_ovf", 32'(overflow), 0);
        out_ready = 1'b1;
        repeat (4) step(1'b0, 16'h0);
        out_ready = 1'b0;
        check("pp_drained", 32'(fifo_count), 0);

        // Reset mid-flight, asserted between edges with data queued
        step(1'b1, 16'h0011);
        repeat (4) step(1'b0, 16'h0);
        check("mf_pre_count", 32'(fifo_count), 1);
        step(1'b1, 16'h0077);
        step(1'b0, 16'h0);
        #2;
        reset = 1'b1;
        #1;
        check("mf_async_count", 32'(fifo_count), 0);
        check("mf_async_valid", 32'(out_valid), 0);
        check("mf_async_data", 32'(out_data), 0);
        repeat (2) step(1'b0, 16'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0);
            check("mf_count", 32'(fifo_count), 0);
            check("mf_valid", 32'(out_valid), 0);
        end
        check("mf_ovf", 32'(overflow), 0);

        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_out_collector.md
FIR_OUT_COLLECTOR -- requirements
Module: fir_out_collector

Interface
REQ-001 SHALL have parameter SIZE, default 8, the PE sample/coefficient width; pe_y is 2*SIZE bits.
REQ-002 SHALL have parameter TAPS, default 4, the number of PEs in the chain and the valid-alignment depth (legal range 1..32).
REQ-003 SHALL have parameter SHIFT, default 0, the right-shift applied to pe_y before narrowing (legal range 0..SIZE).
REQ-004 SHALL have parameter DEPTH, default 4, the output FIFO entries (power of two, 2 or more).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: high in the cycle a valid sample is driven into the first PE's in_x.
REQ-008 SHALL have port pe_y, input, 2*SIZE bits: the last PE's out_y, unsigned.
REQ-009 SHALL have port out_data, output, SIZE bits: the FIFO head result.
REQ-010 SHALL have port out_valid, output, 1 bit: high when the FIFO is not empty.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts out_data on an edge where out_valid and out_ready are both high.
REQ-012 SHALL have port fifo_count, output, $clog2(DEPTH)+1 bits: the number of occupied entries.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag for a dropped result.

Function
REQ-014 SHALL keep a TAPS-stage valid delay line; stage 0 loads in_valid and stage i loads stage i-1 on every edge.
REQ-015 SHALL capture pe_y on the edge following the edge where stage TAPS-1 became high, so in_valid high before edge k writes the result at edge k+TAPS.
REQ-016 SHALL compute the result as pe_y logically shifted right by SHIFT, then narrowed to SIZE bits per REQ-027/REQ-028.
REQ-017 SHALL accept a write into the FIFO when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-018 SHALL pop on an edge where out_valid and out_ready are both high.
REQ-019 SHALL, on simultaneous push and pop, keep fifo_count unchanged and preserve order.
REQ-020 SHALL NOT bypass when empty: a result written at edge k first appears on out_valid/out_data after edge k.
REQ-021 SHALL, when a write arrives while full with no pop, drop the result, leave the contents unchanged and set overflow; overflow stays high until reset.
REQ-022 SHALL ignore out_ready while the FIFO is empty; fifo_count never underflows.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH and distinguish full from empty by the extra count bit.
REQ-024 SHALL accept back-to-back in_valid pulses at full rate, one result per cycle.

Reset
REQ-025 SHALL, while reset is high and asynchronously on assertion, clear the delay line, the pointers, fifo_count and overflow, and drive out_valid=0 and out_data=0.
REQ-026 SHALL discard samples in flight in the PE chain when reset is asserted mid-operation; no write occurs for them after reset is released.

Configuration
REQ-027 SHALL, with macro FIR_COLLECT_SAT_EN defined, saturate the shifted value to 2^SIZE-1 when it exceeds that value.
REQ-028 SHALL, without FIR_COLLECT_SAT_EN, take the low SIZE bits of the shifted value (wrap-around).

Structure
REQ-029 SHALL take the SIZE default, the narrowing function and the FIFO count-width constant from shared package fir_pkg.
REQ-030 SHALL implement the FIFO storage and pointers in one sub-module named collector_fifo; the delay line and narrowing stay in the top module.

Verification (SIZE=8, TAPS=4, DEPTH=4)
REQ-031 SHALL cover alignment: in_valid one cycle, pe_y=16'h0042 held -> write at edge k+4, out_valid rises after that edge, out_data=8'h42.
REQ-032 SHALL cover narrowing: SHIFT=4, pe_y=16'h1234 -> out_data=8'hFF with the macro defined, 8'h23 without.
REQ-033 SHALL cover fill/overflow: out_ready=0, six consecutive valid samples 1..6 -> fifo_count=4, overflow=1, drain yields 1,2,3,4.
REQ-034 SHALL cover full push/pop: full FIFO, out_ready=1 with a concurrent write of 9 -> fifo_count stays 4, no overflow, 9 is last out.
REQ-035 SHALL cover reset mid-flight: reset pulsed two cycles after in_valid -> no write ever occurs, fifo_count=0, overflow=0.
REQ-036 SHALL cover the empty case: out_ready=1 with FIFO empty for 10 cycles -> fifo_count=0, out_valid=0.
